// File: rtl/pipe_addsub_pkg.sv
//------------------------------------------------------------------------------
// Package : pipe_addsub_pkg
// Brief   : Shared operation encodings for the pipelined adder/subtractor.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/addsub_chunk.sv
//------------------------------------------------------------------------------
// Module : addsub_chunk
// Brief  : Combinational CHUNK-bit ripple of full-adder cells, operand b
//          arrives already conditioned for subtract.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] | b[i]));
        end
    end

    assign cout = w_c[CHUNK];
    assign cmsb = w_c[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/pipe_addsub.sv
//------------------------------------------------------------------------------
// Module : pipe_addsub
// Brief  : Pipelined two's-complement add/subtract, one CHUNK slice per stage,
//          valid/ready handshake with carry, overflow and zero flags.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;

    // Per-stage inputs: stage 0 is fed by the ports, stage k by register k-1.
    logic             w_v_in   [STAGES];
    logic             w_c_in   [STAGES];
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_sum_in [STAGES];

    logic [CHUNK-1:0] w_s        [STAGES];
    logic             w_co       [STAGES];
    logic             w_cm       [STAGES];
    logic [WIDTH-1:0] w_sum_next [STAGES];

    logic             r_v   [STAGES];
    logic             r_c   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_cmsb;
    logic             r_zero;

    assign w_adv = !r_v[STAGES-1] || out_ready;

    always_comb begin
        w_b_eff = b;
        case (sub)
            OP_ADD: w_b_eff = b;
            OP_SUB: w_b_eff = ~b;
        endcase
    end

    // Operand remainders shift down one slice per stage; the sum fills in from
    // the top, so after STAGES shifts the full word is aligned.
    always_comb begin
        w_v_in[0]   = in_valid;
        w_c_in[0]   = cin;
        w_a_in[0]   = a;
        w_b_in[0]   = w_b_eff;
        w_sum_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_v_in[k]   = r_v[k-1];
            w_c_in[k]   = r_c[k-1];
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
            w_sum_in[k] = r_sum[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a    (w_a_in[k][CHUNK-1:0]),
            .b    (w_b_in[k][CHUNK-1:0]),
            .cin  (w_c_in[k]),
            .s    (w_s[k]),
            .cout (w_co[k]),
            .cmsb (w_cm[k])
        );

        assign w_sum_next[k] = (w_sum_in[k] >> CHUNK) | (WIDTH'(w_s[k]) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]   <= 1'b0;
                r_c[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
            r_cmsb <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]   <= w_v_in[k];
                r_c[k]   <= w_co[k];
                r_a[k]   <= w_a_in[k] >> CHUNK;
                r_b[k]   <= w_b_in[k] >> CHUNK;
                r_sum[k] <= w_sum_next[k];
            end
            r_cmsb <= w_cm[STAGES-1];
            r_zero <= (w_sum_next[STAGES-1] == '0);
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_v[STAGES-1];
    assign s         = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_cmsb ^ r_c[STAGES-1];
    assign zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_pipe_addsub.sv
//------------------------------------------------------------------------------
// Module : tb_pipe_addsub
// Brief  : Scoreboard bench for pipe_addsub (WIDTH=8, CHUNK=4).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_addsub;
    import pipe_addsub_pkg::*;

    localparam int WIDTH = 8;
    localparam int CHUNK = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
        logic             zero;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_cur;
    exp_t mon_exp;
    exp_t held_val;
    logic held = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   stall_n;

    always #5 clk = ~clk;

    pipe_addsub #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares each handshaked result with the oldest expected entry
    // and verifies outputs stay frozen while the consumer stalls.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (out_valid) begin
            mon_cur = {s, cout, ovf, zero};
            if (held) check("hold_stable", 32'(mon_cur), 32'(held_val));
            if (!out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                held     = 1'b1;
                held_val = mon_cur;
            end else begin
                held = 1'b0;
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 32'(mon_cur), 32'hFFFF_FFFF);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("result", 32'(mon_cur), 32'(mon_exp));
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                        input logic tsub, input logic tcin,
                        input logic [WIDTH-1:0] es, input logic ec,
                        input logic eo, input logic ez);
        int waits = 0;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_b;
        sub      = tsub;
        cin      = tcin;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back({es, ec, eo, ez});
                break;
            end
            waits++;
            if (waits > 50) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = OP_ADD;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_s", 32'(s), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_zero", 32'(zero), 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed arithmetic, including the latency of the first result.
        send(8'h06, 8'h01, OP_SUB, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
        check("latency_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_valid", 32'(out_valid), 32'd1);
        send(8'h04, 8'h06, OP_SUB, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        send(8'h80, 8'h01, OP_SUB, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        send(8'h7F, 8'h01, OP_ADD, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        send(8'hFF, 8'h01, OP_ADD, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        send(8'h05, 8'h03, OP_SUB, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
        drain();

        // Back-to-back ops with a three-cycle consumer stall on the first result.
        fork
            begin
                send(8'h10, 8'h20, OP_ADD, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
                send(8'h05, 8'h05, OP_SUB, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
                send(8'h0F, 8'h01, OP_ADD, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
                send(8'h00, 8'h01, OP_SUB, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
            end
            begin
                stall_n = 0;
                do begin
                    @(posedge clk); #1;
                    stall_n++;
                end while (!out_valid && stall_n < 20);
                check("stall_first_result_seen", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("stall_out_valid_held", 32'(out_valid), 32'd1);
                out_ready = 1'b1;
            end
        join
        drain();

        // Alternating valid/bubble: out_valid toggles one cycle behind.
        send(8'h01, 8'h01, OP_ADD, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        check("bubble_ov_0a", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bubble_ov_1a", 32'(out_valid), 32'd1);
        send(8'h03, 8'h03, OP_SUB, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        check("bubble_ov_0b", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bubble_ov_1b", 32'(out_valid), 32'd1);
        send(8'h40, 8'h40, OP_ADD, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        check("bubble_ov_0c", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bubble_ov_1c", 32'(out_valid), 32'd1);
        send(8'h00, 8'h80, OP_SUB, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        check("bubble_ov_0d", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bubble_ov_1d", 32'(out_valid), 32'd1);
        drain();

        // Asynchronous reset with two ops in flight.
        send(8'h09, 8'h02, OP_SUB, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
        send(8'h01, 8'h02, OP_ADD, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
        #1;
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_s", 32'(s), 32'd0);
        check("async_rst_cout", 32'(cout), 32'd0);
        check("async_rst_zero", 32'(zero), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_output", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined two's-complement adder/subtractor. It splits a WIDTH-bit ripple-carry add (or subtract by A + ~B + cin) into CHUNK-bit slices, with one register stage per slice. It accepts one operation per cycle under a valid/ready handshake and reports carry/borrow, signed overflow and zero flags. It sits in the datapath wherever the combinational ripple subtractor is too slow or too narrow.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of CHUNK, ≥ CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (derived, not overridable).
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted when in_valid && in_ready at the clk edge.
- a  input  WIDTH  minuend / addend.
- b  input  WIDTH  subtrahend / addend.
- sub  input  1  0 = add (a + b + cin), 1 = subtract (a + ~b + cin).
- cin  input  1  carry-in; for subtract, 1 = no incoming borrow (true a − b).
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; in subtract mode 1 = no borrow, 0 = borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  s == 0.

## Operation
- Bit cell: s_i = a_i ^ b'_i ^ c_i; c_{i+1} = a_i&b'_i | c_i&(a_i|b'_i); b' = sub ? ~b : b.
- Stage k (0..STAGES−1) computes bits [k·CHUNK +: CHUNK] from the carry registered by stage k−1. Stage 0 uses cin.
- Each stage register holds: valid, registered carry, result bits produced so far, and the not-yet-consumed upper operand slices (already inverted when sub=1). Operands skew forward with the carry.
- Final stage additionally registers the carry into the MSB and computes cout, ovf and zero from the completed word.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. When adv = 0, every stage holds, bubbles included. Bubbles are not collapsed.
- Accepted operations emerge strictly in order, none dropped or duplicated.
- in_valid = 0 while adv = 1 injects a bubble (valid 0). Data registers may update freely when their valid bit is 0.

## Timing
- Latency STAGES cycles: an op accepted at edge n is on s/flags with out_valid = 1 after edge n+STAGES−1, provided no stall occurs.
- Throughput one op/cycle when out_ready = 1 continuously.
- While out_valid && !out_ready: s, cout, ovf, zero and out_valid are held stable, and in_ready = 0 in the same cycle (combinational from out_valid, out_ready).
- in_ready does not depend on in_valid.
- Reset: on rst rising, immediately (no clk needed) all stage valids = 0, out_valid = 0, s = 0, cout = ovf = 0, zero = 0 (flag registered, cleared, not derived). After release, in_ready = 1.
- Reset mid-operation discards all in-flight ops; none is emitted afterwards.
- STAGES = 1 (CHUNK = WIDTH) degenerates to a single registered full-width ripple unit with the same handshake.

## Structure
- Shared package/include: OP_ADD = 1'b0, OP_SUB = 1'b1 constants; flag bit positions if flags are bundled downstream.
- One sub-module, addsub_chunk: combinational CHUNK-bit ripple of bit cells (a, b', cin in; s, cout, carry-into-MSB out). Instantiated STAGES times via generate.
- No state machine; pipeline control is the single adv enable plus per-stage valid bits.

## Test plan
(WIDTH = 8, CHUNK = 4, latency 2.)
- sub = 1, cin = 1, a = 6, b = 1 -> two cycles later s = 0x05, cout = 1, ovf = 0, zero = 0.
- sub = 1, cin = 1, a = 4, b = 6 -> s = 0xFE, cout = 0 (borrow), ovf = 0; a = 0x80, b = 0x01 -> s = 0x7F, ovf = 1.
- sub = 0, cin = 0, a = 0x7F, b = 0x01 -> s = 0x80, cout = 0, ovf = 1. Then a = 0xFF, b = 0x01 -> s = 0x00, cout = 1, zero = 1.
- Four back-to-back ops with out_ready held 0 for 3 cycles after the first result -> first result held stable, in_ready = 0 during the stall, all four emerge in order, none lost.
- Alternating in_valid 1/0 -> bubbles propagate; out_valid pattern 1,0,1,0 offset by 2 cycles.
- rst pulsed asynchronously with two ops in flight -> out_valid = 0 and s = 0 without a clock edge, and no result appears after release.
